// File: rtl/uart_pkg.sv
// Shared UART-side definitions: FSM state encoding and default widths.
// The TX_RESULT_CHK_EN macro adds the complement-byte states.
package uart_pkg;

    localparam int DBIT_DEF   = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT      = 3'd2
`ifdef TX_RESULT_CHK_EN
        ,
        CHK_START = 3'd3,
        CHK_WAIT  = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/tx_result_queue_if.sv
// Result-in / UART-out handshake bundle for tx_result_queue.
// master = producer/transmitter side, slave = the queue itself.
interface tx_result_queue_if #(
    parameter int DBIT = 8
);
    logic            res_valid;
    logic [DBIT-1:0] res_data;
    logic            tx_done_tick;
    logic            tx_start;
    logic [DBIT-1:0] d_in;
    logic            full;
    logic            empty;
    logic            overflow;

    modport master (
        output res_valid, res_data, tx_done_tick,
        input  tx_start, d_in, full, empty, overflow
    );

    modport slave (
        input  res_valid, res_data, tx_done_tick,
        output tx_start, d_in, full, empty, overflow
    );
endinterface

// File: rtl/tx_result_queue_sync_fifo.sv
// sync_fifo: small register FIFO with registered full/empty/overflow.
// A write while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    input  logic            rd_en,
    output logic [DBIT-1:0] rd_data,
    output logic            full,
    output logic            empty,
    output logic            overflow
);
    localparam int           DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    // storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // pointers, count and registered flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            full     <= (count_next == DEPTH_C);
            empty    <= (count_next == '0);
            overflow <= wr_en && !do_push;
        end
    end

endmodule

// File: rtl/tx_result_queue.sv
// tx_result_queue: buffers ALU result bytes and feeds them to the UART
// transmitter one at a time (tx_start pulse, wait for tx_done_tick).
// Optional macro TX_RESULT_CHK_EN: each result is followed by its complement.
module tx_result_queue
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    tx_result_queue_if.slave bus
);
    state_t          state;
    state_t          state_next;
    logic            tx_start_r;
    logic            tx_start_next;
    logic [DBIT-1:0] d_in_r;
    logic [DBIT-1:0] d_in_next;
    logic [DBIT-1:0] head;
    logic            pop;
    logic            fifo_empty;

    sync_fifo #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (bus.res_valid),
        .wr_data  (bus.res_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (bus.full),
        .empty    (fifo_empty),
        .overflow (bus.overflow)
    );

    assign bus.empty    = fifo_empty;
    assign bus.tx_start = tx_start_r;
    assign bus.d_in     = d_in_r;

    // next-state, next tx_start/d_in and FIFO pop
    always_comb begin
        state_next    = state;
        tx_start_next = 1'b0;
        d_in_next     = d_in_r;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    d_in_next  = head;
                    state_next = START;
                end
            end
            START: begin
                tx_start_next = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                if (bus.tx_done_tick) begin
`ifdef TX_RESULT_CHK_EN
                    // entry stays queued until its check byte is out
                    d_in_next  = ~d_in_r;
                    state_next = CHK_START;
`else
                    pop        = 1'b1;
                    state_next = IDLE;
`endif
                end
            end
`ifdef TX_RESULT_CHK_EN
            CHK_START: begin
                tx_start_next = 1'b1;
                state_next    = CHK_WAIT;
            end
            CHK_WAIT: begin
                if (bus.tx_done_tick) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // state and registered transmitter outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx_start_r <= 1'b0;
            d_in_r     <= '0;
        end else begin
            state      <= state_next;
            tx_start_r <= tx_start_next;
            d_in_r     <= d_in_next;
        end
    end

endmodule
